// File: rtl/pe_input_loader.sv
// ============================================================================
// Module      : pe_input_loader
// Description : Fetches a filter block then an IF block from a 1-cycle-latency
//               memory and writes them into the PE filter / IF buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_input_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] filt_base,
    input  logic [CNT_WIDTH-1:0]  filt_count,
    input  logic [ADDR_WIDTH-1:0] if_base,
    input  logic [CNT_WIDTH-1:0]  if_count,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  filt_wen,
    output logic [DATA_WIDTH-1:0] filt_wdata,
    input  logic                  filt_full,
    output logic                  if_wen,
    output logic [DATA_WIDTH-1:0] if_wdata,
    input  logic                  if_full,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_f_rd  = 3'd1;
    localparam logic [2:0] c_f_cap = 3'd2;
    localparam logic [2:0] c_f_wr  = 3'd3;
    localparam logic [2:0] c_i_rd  = 3'd4;
    localparam logic [2:0] c_i_cap = 3'd5;
    localparam logic [2:0] c_i_wr  = 3'd6;
    localparam logic [2:0] c_done  = 3'd7;

    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [CNT_WIDTH-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [ADDR_WIDTH-1:0] r_filt_base;
    logic [CNT_WIDTH-1:0]  r_filt_count;
    logic [ADDR_WIDTH-1:0] r_if_base;
    logic [CNT_WIDTH-1:0]  r_if_count;

    logic                  w_filt_last;
    logic                  w_if_last;
    logic [ADDR_WIDTH-1:0] w_base;

    assign w_filt_last = (r_idx == (r_filt_count - c_cnt_one));
    assign w_if_last   = (r_idx == (r_if_count - c_cnt_one));

    // Address wraps modulo 2^ADDR_WIDTH by plain truncation of the sum.
    assign w_base   = (r_state == c_i_rd) ? r_if_base : r_filt_base;
    assign mem_addr = w_base + ADDR_WIDTH'(r_idx);

    assign mem_rd     = (r_state == c_f_rd) || (r_state == c_i_rd);
    assign filt_wen   = (r_state == c_f_wr) && !filt_full;
    assign if_wen     = (r_state == c_i_wr) && !if_full;
    assign filt_wdata = r_hold;
    assign if_wdata   = r_hold;
    assign busy       = (r_state != c_idle);
    assign done       = (r_state == c_done);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    if (filt_count != c_cnt_zero) begin
                        w_next_state = c_f_rd;
                    end else if (if_count != c_cnt_zero) begin
                        w_next_state = c_i_rd;
                    end else begin
                        w_next_state = c_done;
                    end
                end
            end
            c_f_rd:  w_next_state = c_f_cap;
            c_f_cap: w_next_state = c_f_wr;
            c_f_wr: begin
                if (!filt_full) begin
                    if (!w_filt_last) begin
                        w_next_state = c_f_rd;
                    end else if (r_if_count != c_cnt_zero) begin
                        w_next_state = c_i_rd;
                    end else begin
                        w_next_state = c_done;
                    end
                end
            end
            c_i_rd:  w_next_state = c_i_cap;
            c_i_cap: w_next_state = c_i_wr;
            c_i_wr: begin
                if (!if_full) begin
                    w_next_state = w_if_last ? c_done : c_i_rd;
                end
            end
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_idx        <= '0;
            r_hold       <= '0;
            r_filt_base  <= '0;
            r_filt_count <= '0;
            r_if_base    <= '0;
            r_if_count   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_filt_base  <= filt_base;
                        r_filt_count <= filt_count;
                        r_if_base    <= if_base;
                        r_if_count   <= if_count;
                        r_idx        <= '0;
                    end
                end
                c_f_cap, c_i_cap: r_hold <= mem_rdata;
                c_f_wr: begin
                    if (!filt_full) begin
                        r_idx <= w_filt_last ? c_cnt_zero : r_idx + c_cnt_one;
                    end
                end
                c_i_wr: begin
                    if (!if_full) begin
                        r_idx <= w_if_last ? c_cnt_zero : r_idx + c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_input_loader.sv
// ============================================================================
// Module      : tb_pe_input_loader
// Description : Scoreboard bench for pe_input_loader with directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_input_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] filt_base = '0;
    logic [7:0]  filt_count = '0;
    logic [15:0] if_base = '0;
    logic [7:0]  if_count = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        filt_wen;
    logic [31:0] filt_wdata;
    logic        filt_full = 1'b0;
    logic        if_wen;
    logic [31:0] if_wdata;
    logic        if_full = 1'b0;
    logic        busy;
    logic        done;

    pe_input_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_base(filt_base), .filt_count(filt_count),
        .if_base(if_base), .if_count(if_count),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .filt_wen(filt_wen), .filt_wdata(filt_wdata), .filt_full(filt_full),
        .if_wen(if_wen), .if_wdata(if_wdata), .if_full(if_full),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: data = address ^ 0xA5A5_0000, one cycle after the read.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= {16'hA5A5, mem_addr};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errs = 0;
    int t0 = 0;
    int exp_done = 0;
    int done_cnt = 0;
    bit active = 1'b0;

    logic [15:0] q_rd[$];
    logic [31:0] q_fw[$];
    logic [31:0] q_iw[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a strobe is seen.
    always @(negedge clk) begin
        if (active) begin
            int rel;
            rel = cyc - t0 + 1;
            if (mem_rd) begin
                if (q_rd.size() == 0) chk("unexpected_mem_rd", {16'h0, mem_addr}, 32'hFFFFFFFF);
                else chk("mem_addr", {16'h0, mem_addr}, {16'h0, q_rd.pop_front()});
            end
            if (filt_wen) begin
                if (q_fw.size() == 0) chk("unexpected_filt_wen", filt_wdata, 32'hFFFFFFFF);
                else chk("filt_wdata", filt_wdata, q_fw.pop_front());
                chk("filt_wen_while_full", {31'h0, filt_full}, 32'h0);
            end
            if (if_wen) begin
                if (q_iw.size() == 0) chk("unexpected_if_wen", if_wdata, 32'hFFFFFFFF);
                else chk("if_wdata", if_wdata, q_iw.pop_front());
            end
            if (filt_wen || if_wen) chk("wen_exclusive", {31'h0, filt_wen & if_wen}, 32'h0);
            if (done) begin
                done_cnt++;
                chk("done_cycle", rel, exp_done);
            end
            if (exp_done > 0 && rel <= exp_done + 2)
                chk("busy", {31'h0, busy}, {31'h0, (rel <= exp_done)});
        end
    end

    task automatic run_job(input logic [15:0] fb, input int fc, input logic [15:0] ib,
                           input int ic, input int bp_len, input int rst_at, input bit mid_start);
        int lim;
        int k;
        bit seen;
        lim = (rst_at > 0) ? rst_at : 1000000;
        k = 0;
        for (int i = 0; i < fc; i++) begin
            if (3*k+1 <= lim) q_rd.push_back(fb + 16'(i));
            if (3*k+3 <= lim) q_fw.push_back({16'hA5A5, 16'(fb + 16'(i))});
            k++;
        end
        for (int i = 0; i < ic; i++) begin
            if (3*k+1 <= lim) q_rd.push_back(ib + 16'(i));
            if (3*k+3 <= lim) q_iw.push_back({16'hA5A5, 16'(ib + 16'(i))});
            k++;
        end
        exp_done = (rst_at > 0) ? -1 : 3*(fc+ic) + 1 + bp_len;
        done_cnt = 0;
        @(negedge clk);
        filt_base = fb; filt_count = 8'(fc); if_base = ib; if_count = 8'(ic);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        active = 1'b1;
        if (bp_len > 0) begin
            repeat (2) @(posedge clk);
            #1 filt_full = 1'b1;
            repeat (bp_len) @(posedge clk);
            #1 filt_full = 1'b0;
        end
        if (mid_start) begin
            repeat (4) @(posedge clk);
            #1;
            filt_base = 16'h2000; if_base = 16'h3000; filt_count = 8'd1; if_count = 8'd1;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
            chk("rst_filt_wen", {31'h0, filt_wen}, 32'h0);
            chk("rst_if_wen", {31'h0, if_wen}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
            repeat (20) @(posedge clk);
        end else begin
            seen = 1'b0;
            for (int w = 0; w < 300 && !seen; w++) begin
                @(posedge clk);
                seen = (done_cnt > 0);
            end
            if (!seen) chk("done_timeout", 32'h0, 32'h1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt, (rst_at > 0) ? 0 : 1);
        chk("rd_left", q_rd.size(), 0);
        chk("fw_left", q_fw.size(), 0);
        chk("iw_left", q_iw.size(), 0);
        active = 1'b0;
        q_rd.delete(); q_fw.delete(); q_iw.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("reset_filt_wen", {31'h0, filt_wen}, 32'h0);
        chk("reset_if_wen", {31'h0, if_wen}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("reset_filt_wdata", filt_wdata, 32'h0);
        chk("reset_if_wdata", if_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);

        run_job(16'h0010, 2, 16'h0100, 3, 0, 0, 1'b0);   // basic, done cycle 16
        run_job(16'h0010, 2, 16'h0100, 3, 4, 0, 1'b0);   // backpressure, done cycle 20
        run_job(16'h0040, 0, 16'h0200, 2, 0, 0, 1'b0);   // IF only, done cycle 7
        run_job(16'h0050, 0, 16'h0300, 0, 0, 0, 1'b0);   // empty job, done cycle 1
        run_job(16'h0000, 0, 16'hFFFE, 4, 0, 0, 1'b0);   // address wrap
        run_job(16'h0010, 2, 16'h0100, 3, 0, 12, 1'b0);  // reset in second I_WR
        run_job(16'h0010, 2, 16'h0100, 3, 0, 0, 1'b0);   // full job after abort
        run_job(16'h0010, 2, 16'h0100, 3, 0, 0, 1'b1);   // start while busy ignored

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
